// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the DLX memory arbiter.
//   arb_state_t  : arbiter FSM states
//   grant_t      : identifies which requester was granted most recently
//   TIMER_W      : width of the access timeout counter
//   TIMEOUT_DATA : read data returned when an access times out
package dlx_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ACC,
    ST_CPU_DONE,
    ST_DBG_ACC,
    ST_DBG_DONE
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_DBG
  } grant_t;

  localparam int          TIMER_W      = 16;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dlx_mem_timer.sv
// Access timeout counter.
// It loads TIMEOUT-1 on clear and then counts down while enabled.
// tc is high when the count reaches zero, which is the TIMEOUT-th enabled cycle after a clear.
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload the counter (start of a new access)
//   enable     : count this cycle (access in flight)
//   tc         : terminal count reached
module dlx_mem_timer
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Shares the single-port DLX main memory between the DLX control FSM (MR/MW with a busy
// stall) and the debug/loader port. Ties are resolved round-robin, and only one memory
// access is outstanding at a time. Each access has a timeout; a timeout sets a sticky error.
//   clk, reset           : clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata : DLX memory request (a write wins when rd and wr are both high)
//   cpu_rdata, cpu_busy  : read data (valid when busy falls) and stall to the DLX FSM
//   dbg_rd/wr/addr/wdata : debug request, held until dbg_ack
//   dbg_rdata, dbg_ack   : debug read data and one-cycle completion pulse
//   mem_*                : registered request to memory; mem_rdata/mem_ack from memory
//   err                  : sticky timeout flag, cleared only by reset
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no access in flight; arbitrate and latch the winner
// ST_CPU_ACC  | CPU access in flight, waiting for mem_ack or timeout
// ST_CPU_DONE | CPU access finished; busy is low and cpu_rdata is valid
// ST_DBG_ACC  | debug access in flight, waiting for mem_ack or timeout
// ST_DBG_DONE | debug access finished; dbg_ack is pulsed
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  input  logic              dbg_rd,
  input  logic              dbg_wr,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;

  logic cpu_req, dbg_req;
  logic grant_cpu, grant_dbg;
  logic acc_ok, acc_timeout, acc_is_cpu;
  logic timer_tc, timer_en;

  // The memory is word-addressed, so address bits above MEM_AW-1 are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:MEM_AW], dbg_addr[31:MEM_AW]};

  assign cpu_req = cpu_rd | cpu_wr;
  assign dbg_req = dbg_rd | dbg_wr;

  // Busy is combinational so the DLX stalls in the same cycle it raises MR/MW.
  assign cpu_busy   = cpu_req & (state_q != ST_CPU_DONE);
  assign dbg_ack    = (state_q == ST_DBG_DONE);
  assign acc_is_cpu = (state_q == ST_CPU_ACC);
  assign timer_en   = (state_q == ST_CPU_ACC) || (state_q == ST_DBG_ACC);

  dlx_mem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (grant_cpu | grant_dbg),
    .enable(timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_cpu   = 1'b0;
    grant_dbg   = 1'b0;
    acc_ok      = 1'b0;
    acc_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && (!dbg_req || (last_grant_q == GRANT_DBG))) begin
          grant_cpu = 1'b1;
          state_d   = ST_CPU_ACC;
        end else if (dbg_req) begin
          grant_dbg = 1'b1;
          state_d   = ST_DBG_ACC;
        end
      end
      ST_CPU_ACC, ST_DBG_ACC: begin
        // An ack in the terminal-count cycle still counts as success.
        if (mem_ack) begin
          acc_ok = 1'b1;
        end else if (timer_tc) begin
          acc_timeout = 1'b1;
        end
        if (mem_ack || timer_tc) begin
          state_d = (state_q == ST_CPU_ACC) ? ST_CPU_DONE : ST_DBG_DONE;
        end
      end
      ST_CPU_DONE, ST_DBG_DONE: state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
      err          <= 1'b0;
      last_grant_q <= GRANT_DBG;
    end else begin
      if (grant_cpu) begin
        mem_req      <= 1'b1;
        mem_we       <= cpu_wr;
        mem_addr     <= cpu_addr[MEM_AW-1:0];
        mem_wdata    <= cpu_wdata;
        last_grant_q <= GRANT_CPU;
      end else if (grant_dbg) begin
        mem_req      <= 1'b1;
        mem_we       <= dbg_wr;
        mem_addr     <= dbg_addr[MEM_AW-1:0];
        mem_wdata    <= dbg_wdata;
        last_grant_q <= GRANT_DBG;
      end

      if (acc_ok || acc_timeout) begin
        mem_req <= 1'b0;
      end

      // A successful write keeps the previous read data.
      if (acc_ok && !mem_we) begin
        if (acc_is_cpu) cpu_rdata <= mem_rdata;
        else            dbg_rdata <= mem_rdata;
      end

      if (acc_timeout) begin
        err <= 1'b1;
        if (acc_is_cpu) cpu_rdata <= DATA_W'(TIMEOUT_DATA);
        else            dbg_rdata <= DATA_W'(TIMEOUT_DATA);
      end
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
module tb_dlx_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, dbg_rd, dbg_wr;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic        cpu_busy, dbg_ack, mem_req, mem_we, mem_ack, err;
  logic [9:0]  mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dlx_mem_arbiter #(.DATA_W(32), .MEM_AW(10), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  typedef struct packed {
    logic        rst, crd, cwr;
    logic [31:0] caddr;
    logic        drd, dwr;
    logic [31:0] daddr, dwdata;
    logic        mack;
    logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic        busy;
    logic [31:0] crdata;
    logic        dack;
    logic [31:0] drdata;
    logic        mreq, mwe;
    logic [9:0]  maddr;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl[NVEC];

  function automatic vec_t v(
    input logic rst, crd, cwr, input logic [31:0] caddr,
    input logic drd, dwr, input logic [31:0] daddr, dwdata,
    input logic mack, input logic [31:0] mrdata,
    input logic busy, input logic [31:0] crdata, input logic dack, input logic [31:0] drdata,
    input logic mreq, mwe, input logic [9:0] maddr, input logic e);
    vec_t r;
    r.i = '{rst, crd, cwr, caddr, drd, dwr, daddr, dwdata, mack, mrdata};
    r.o = '{busy, crdata, dack, drdata, mreq, mwe, maddr, e};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_rd = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  out_t act;
  int   n;

  initial begin
    // rst crd cwr caddr | drd dwr daddr dwdata | mack mrdata || busy crdata dack drdata mreq mwe maddr err
    tbl[0]  = v(1,0,0,'h00, 0,0,'h00,'h0000, 0,'h0,          0,'h0,0,'h0, 0,0,'h000,0);
    tbl[1]  = v(0,1,0,'h40, 0,0,'h00,'h0000, 0,'h0,          1,'h0,0,'h0, 0,0,'h000,0);
    tbl[2]  = v(0,1,0,'h40, 0,0,'h00,'h0000, 0,'h0,          1,'h0,0,'h0, 1,0,'h040,0);
    tbl[3]  = v(0,1,0,'h40, 0,0,'h00,'h0000, 0,'h0,          1,'h0,0,'h0, 1,0,'h040,0);
    tbl[4]  = v(0,1,0,'h40, 0,0,'h00,'h0000, 1,'h8C220004,   1,'h0,0,'h0, 1,0,'h040,0);
    tbl[5]  = v(0,1,0,'h40, 0,0,'h00,'h0000, 0,'h0,          0,'h8C220004,0,'h0, 0,0,'h040,0);
    tbl[6]  = v(0,0,0,'h00, 0,0,'h00,'h0000, 0,'h0,          0,'h8C220004,0,'h0, 0,0,'h040,0);
    tbl[7]  = v(1,0,0,'h00, 0,0,'h00,'h0000, 0,'h0,          0,'h8C220004,0,'h0, 0,0,'h040,0);
    tbl[8]  = v(0,1,0,'h20, 0,1,'h10,'h1234, 0,'h0,          1,'h0,0,'h0, 0,0,'h000,0);
    tbl[9]  = v(0,1,0,'h20, 0,1,'h10,'h1234, 1,'hA5A5,       1,'h0,0,'h0, 1,0,'h020,0);
    tbl[10] = v(0,0,0,'h00, 0,1,'h10,'h1234, 0,'h0,          0,'hA5A5,0,'h0, 0,0,'h020,0);
    tbl[11] = v(0,0,0,'h00, 0,1,'h10,'h1234, 0,'h0,          0,'hA5A5,0,'h0, 0,0,'h020,0);
    tbl[12] = v(0,0,0,'h00, 0,1,'h10,'h1234, 0,'h0,          0,'hA5A5,0,'h0, 1,1,'h010,0);
    tbl[13] = v(0,0,0,'h00, 0,1,'h10,'h1234, 1,'hFFFF,       0,'hA5A5,0,'h0, 1,1,'h010,0);
    tbl[14] = v(0,0,0,'h00, 0,1,'h10,'h1234, 0,'h0,          0,'hA5A5,1,'h0, 0,1,'h010,0);
    tbl[15] = v(0,0,0,'h00, 0,0,'h00,'h0000, 0,'h0,          0,'hA5A5,0,'h0, 0,1,'h010,0);
    tbl[16] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'hA5A5,0,'h0, 0,1,'h010,0);
    tbl[17] = v(0,1,0,'h30, 1,0,'h31,'h0000, 1,'h11,         1,'hA5A5,0,'h0, 1,0,'h030,0);
    tbl[18] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          0,'h11,0,'h0,   0,0,'h030,0);
    tbl[19] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'h11,0,'h0,   0,0,'h030,0);
    tbl[20] = v(0,1,0,'h30, 1,0,'h31,'h0000, 1,'h22,         1,'h11,0,'h0,   1,0,'h031,0);
    tbl[21] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'h11,1,'h22,  0,0,'h031,0);
    tbl[22] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'h11,0,'h22,  0,0,'h031,0);
    tbl[23] = v(0,1,0,'h30, 1,0,'h31,'h0000, 1,'h33,         1,'h11,0,'h22,  1,0,'h030,0);
    tbl[24] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          0,'h33,0,'h22,  0,0,'h030,0);
    tbl[25] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'h33,0,'h22,  0,0,'h030,0);
    tbl[26] = v(0,1,0,'h30, 1,0,'h31,'h0000, 0,'h0,          1,'h33,0,'h22,  1,0,'h031,0);
    tbl[27] = v(0,1,0,'h30, 1,0,'h31,'h0000, 1,'h44,         1,'h33,0,'h22,  1,0,'h031,0);
    tbl[28] = v(0,0,0,'h00, 0,0,'h00,'h0000, 0,'h0,          0,'h33,1,'h44,  0,0,'h031,0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NVEC; k++) begin
      reset    = tbl[k].i.rst;
      cpu_rd   = tbl[k].i.crd;   cpu_wr   = tbl[k].i.cwr;   cpu_addr  = tbl[k].i.caddr;
      dbg_rd   = tbl[k].i.drd;   dbg_wr   = tbl[k].i.dwr;   dbg_addr  = tbl[k].i.daddr;
      dbg_wdata = tbl[k].i.dwdata;
      mem_ack  = tbl[k].i.mack;  mem_rdata = tbl[k].i.mrdata;
      @(negedge clk);
      act = '{cpu_busy, cpu_rdata, dbg_ack, dbg_rdata, mem_req, mem_we, mem_addr, err};
      checks++;
      if (act !== tbl[k].o) begin
        errors++;
        $display("FAIL vec%0d: got busy=%b crd=%h dack=%b drd=%h req=%b we=%b addr=%h err=%b expected busy=%b crd=%h dack=%b drd=%h req=%b we=%b addr=%h err=%b",
                 k, act.busy, act.crdata, act.dack, act.drdata, act.mreq, act.mwe, act.maddr, act.err,
                 tbl[k].o.busy, tbl[k].o.crdata, tbl[k].o.dack, tbl[k].o.drdata, tbl[k].o.mreq,
                 tbl[k].o.mwe, tbl[k].o.maddr, tbl[k].o.err);
      end
      @(posedge clk);
      #1;
    end

    // Timeout: no mem_ack, TIMEOUT=8.
    idle_inputs();
    cpu_rd = 1'b1; cpu_addr = 32'h55;
    @(posedge clk); #1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", n, 8);
    chk("timeout_busy", {31'b0, cpu_busy}, 0);
    chk("timeout_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("timeout_err", {31'b0, err}, 1);

    // A later successful debug read leaves err set.
    @(posedge clk); #1;
    cpu_rd = 1'b0; dbg_rd = 1'b1; dbg_addr = 32'h5;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h77;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; dbg_rd = 1'b0;
    @(negedge clk);
    chk("after_to_dack", {31'b0, dbg_ack}, 1);
    chk("after_to_drdata", dbg_rdata, 32'h77);
    chk("err_sticky", {31'b0, err}, 1);
    @(posedge clk); #1;

    // Reset in the middle of a debug access; a late mem_ack is ignored.
    dbg_wr = 1'b1; dbg_addr = 32'h12; dbg_wdata = 32'hBEEF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("dbg_acc_req", {31'b0, mem_req}, 1);
    chk("dbg_acc_wdata", mem_wdata, 32'hBEEF);
    reset = 1'b1; dbg_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_dack", {31'b0, dbg_ack}, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'b0, mem_req}, 0);
    chk("late_ack_dack", {31'b0, dbg_ack}, 0);
    chk("rst_crdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;

    // rd and wr together: write wins, upper address bits dropped.
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h7FF; cpu_wdata = 32'hCAFE;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdwr_req", {31'b0, mem_req}, 1);
    chk("rdwr_we", {31'b0, mem_we}, 1);
    chk("rdwr_addr", {22'b0, mem_addr}, 32'h3FF);
    chk("rdwr_wdata", mem_wdata, 32'hCAFE);
    mem_ack = 1'b1; mem_rdata = 32'h9999;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rdwr_busy", {31'b0, cpu_busy}, 0);
    chk("rdwr_keep_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
